io_port_client: RTL
===================

// Module: io_port_client
// PURPOSE
//  Device-side initiator for one slot of the round-robin IO arbiter. Queues read/write requests
//  from an IO device (VGA fetch, keyboard, ...) and presents one at a time on the arbiter slot
//  (address, write data, direction). Completes each request on the slot's one-cycle grant.
//  Returns read data via a valid/ready handshake and write completion as a pulse.
//  One instance per arbiter slot; outputs wire to the arbiter's per-slot input arrays.
// PARAMETERS
//  FIFO_DEPTH  4              request queue entries; power of two, >= 2
//  TIMEOUT     4*gc::IO_COUNT cycles waiting for a grant before starveErr is set
// PORTS
//  clk         in   1          clock; all state on posedge
//  rst         in   1          asynchronous, active-high reset
//  reqValid    in   1          device request present
//  reqReady    out  1          request accepted when reqValid && reqReady
//  reqWrite    in   1          1 = write to memory (gc::IO_IN), 0 = read (gc::IO_OUT)
//  reqAddr     in   WORD_SIZE  memory address
//  reqWdata    in   WORD_SIZE  write data (ignored for reads)
//  rspValid    out  1          read data available
//  rspReady    in   1          device consumes read data
//  rspData     out  WORD_SIZE  read data
//  wrDone      out  1          one-cycle pulse per completed write
//  starveErr   out  1          sticky: grant not seen within TIMEOUT cycles
//  arbAddress  out  WORD_SIZE  to arbiter addressIn for this slot
//  arbDataOut  out  WORD_SIZE  to arbiter dataIn for this slot
//  arbDir      out  1          to arbiter dataDir for this slot
//  arbDataIn   in   WORD_SIZE  from arbiter dataOut for this slot
//  arbValid    in   1          from arbiter dataValid for this slot; high for one grant cycle
// BEHAVIOUR
//  Reset (async, immediate):
//   FIFO empty; state IDLE; arbAddress=0, arbDataOut=0, arbDir=gc::IO_OUT.
//   rspValid=0, rspData=0, wrDone=0, starveErr=0, wait counter 0.
//   In-flight request dropped; no wrDone or rspValid is produced for it.
//  Queue:
//   - reqReady = !full. Push on reqValid && reqReady; no bypass when full.
//   - Pop occurs only when loading the issue registers; push and pop in the same cycle are both legal.
//  Issue registers (arbAddress/arbDataOut/arbDir):
//   - Registered; loaded from the FIFO head.
//   - Held stable for the whole ISSUE state.
//  FSM:
//   IDLE:  FIFO non-empty -> load head, pop, go ISSUE (arb outputs valid the next cycle).
//          arbDir forced IO_OUT; arbAddress holds its last value.
//   ISSUE: wait counter increments each cycle; at count == TIMEOUT set starveErr and keep waiting.
//          Posedge with arbValid=1 completes the request; the wait counter clears.
//          Write: wrDone=1 the next cycle. If the FIFO is non-empty, load the next head and stay
//          in ISSUE; else go IDLE.
//          Read: rspData <= arbDataIn; rspValid=1 the next cycle; go RESP.
//   RESP:  rspValid and rspData held until rspReady=1. On that edge rspValid drops, then:
//          FIFO non-empty -> load next head, go ISSUE; else go IDLE. No new issue occurs while in RESP.
//  arbValid is ignored outside ISSUE.
//  Latency: push to arb outputs valid >= 2 cycles; grant edge to wrDone/rspValid = 1 cycle.
//  Ordering: strict FIFO order; every request completes exactly once.
//  Widths: all data/address are gc::WORD_SIZE, with no arithmetic on them.
//   Wait counter width is $clog2(TIMEOUT+1) and saturates at TIMEOUT.
//  starveErr clears only on rst.
// STRUCTURE
//  Package gc: WORD_SIZE, IO_COUNT, IO_IN, IO_OUT (existing).
//   Add io_req_t packed struct {write, addr, wdata}.
//   Add io_client_state_t enum {IDLE, ISSUE, RESP}.
//  Sub-module io_req_fifo: parameterised FIFO of io_req_t.
//   Ports push/pop/full/empty/head; pointer wrap by power-of-two masking.
//  Top: FSM, issue registers, response register, wait counter.
// TESTING
//  1. Write addr 0x10 data 0xAB; arbValid pulsed 3 cycles after ISSUE entry.
//     -> arbDir=IO_IN, arbAddress=0x10, arbDataOut=0xAB held until the pulse; wrDone 1 cycle; FSM IDLE.
//  2. Read addr 0x20; arbDataIn=0x5A on the grant; rspReady low 5 cycles.
//     -> rspValid/rspData=0x5A held 5 cycles, drops the cycle after rspReady.
//  3. Five pushes with no grants, FIFO_DEPTH=4.
//     -> 1 in issue regs + 4 queued; reqReady=0; a 6th push is not accepted; grants then drain in order.
//  4. Hold ISSUE with no arbValid.
//     -> starveErr rises exactly TIMEOUT cycles after ISSUE entry and stays set; a later grant still completes.
//  5. Assert rst mid-ISSUE on a write.
//     -> all outputs at reset values immediately; no wrDone; FIFO empty.
//  6. Eight mixed R/W requests, arbValid every 4 cycles (IO_COUNT=4), rspReady=1.
//     -> one completion per grant, in push order, with data matching a memory model.

Source files
------------

// File: rtl/gc.sv
// gc: shared IO bus constants and the request/state types used by the arbiter slot clients.
package gc;
  localparam int   WORD_SIZE = 16;
  localparam int   IO_COUNT  = 4;
  localparam logic IO_IN     = 1'b1;
  localparam logic IO_OUT    = 1'b0;
  typedef struct packed {
    logic                 write;
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] wdata;
  } io_req_t;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} io_client_state_t;
endpackage

// File: rtl/io_req_fifo.sv
// io_req_fifo: power-of-two request queue; pointers carry one extra wrap bit to tell full from empty.
module io_req_fifo
  import gc::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  io_req_t din,
  output logic    full,
  output logic    empty,
  output io_req_t head
);
  localparam int AW = $clog2(DEPTH);
  io_req_t        r_mem [DEPTH];
  logic    [AW:0] r_wp;
  logic    [AW:0] r_rp;
  assign full  = (r_wp ^ r_rp) == {1'b1, {AW{1'b0}}};
  assign empty = r_wp == r_rp;
  assign head  = r_mem[r_rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (push && !full) r_wp <= r_wp + 1'b1;
      if (pop && !empty) r_rp <= r_rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full) r_mem[r_wp[AW-1:0]] <= din;
endmodule

// File: rtl/io_port_client.sv
// io_port_client: queues device requests and issues them one at a time on an IO arbiter slot.
module io_port_client
  import gc::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 4 * IO_COUNT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic                 reqWrite,
  input  logic [WORD_SIZE-1:0] reqAddr,
  input  logic [WORD_SIZE-1:0] reqWdata,
  output logic                 rspValid,
  input  logic                 rspReady,
  output logic [WORD_SIZE-1:0] rspData,
  output logic                 wrDone,
  output logic                 starveErr,
  output logic [WORD_SIZE-1:0] arbAddress,
  output logic [WORD_SIZE-1:0] arbDataOut,
  output logic                 arbDir,
  input  logic [WORD_SIZE-1:0] arbDataIn,
  input  logic                 arbValid
);
  localparam int CW = $clog2(TIMEOUT + 1);
  io_client_state_t r_state;
  io_client_state_t w_next;
  io_req_t          w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_load;
  logic             w_grant;
  logic             w_wait;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_inc;
  assign reqReady  = !w_full;
  assign w_grant   = r_state == ISSUE && arbValid;
  assign w_wait    = r_state == ISSUE && !arbValid;
  assign w_cnt_inc = (r_cnt == CW'(TIMEOUT)) ? r_cnt : r_cnt + 1'b1;
  io_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (reqValid),
    .pop  (w_load),
    .din  ({reqWrite, reqAddr, reqWdata}),
    .full (w_full),
    .empty(w_empty),
    .head (w_head)
  );
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      IDLE: begin
        w_next = w_empty ? IDLE : ISSUE;
        w_load = !w_empty;
      end
      ISSUE: if (arbValid) begin
        w_next = (arbDir == IO_OUT) ? RESP : (w_empty ? IDLE : ISSUE);
        w_load = arbDir == IO_IN && !w_empty;
      end
      RESP: if (rspReady) begin
        w_next = w_empty ? IDLE : ISSUE;
        w_load = !w_empty;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      arbAddress <= '0;
      arbDataOut <= '0;
      arbDir     <= IO_OUT;
      rspValid   <= 1'b0;
      rspData    <= '0;
      wrDone     <= 1'b0;
      starveErr  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) {arbDir, arbAddress, arbDataOut} <= w_head;
      else if (w_next == IDLE) arbDir <= IO_OUT;
      r_cnt <= w_wait ? w_cnt_inc : '0;
      if (w_wait && w_cnt_inc == CW'(TIMEOUT)) starveErr <= 1'b1;
      wrDone <= w_grant && arbDir == IO_IN;
      if (w_grant && arbDir == IO_OUT) begin
        rspValid <= 1'b1;
        rspData  <= arbDataIn;
      end else if (r_state == RESP && rspReady) rspValid <= 1'b0;
    end
endmodule
